// File: rtl/sbox_arbiter_if.sv
// Handshake bundle between the state / key-schedule requesters and sbox_arbiter.
// Byte k of any data word sits at the MSB end first: byte 0 is data[W-1 -: 8].
interface sbox_arbiter_if;
  logic         st_valid;
  logic         st_ready;
  logic [127:0] st_data;
  logic         st_out_valid;
  logic [127:0] st_out;
  logic         kw_valid;
  logic         kw_ready;
  logic [31:0]  kw_data;
  logic         kw_out_valid;
  logic [31:0]  kw_out;
  logic         busy;

  modport master (
    output st_valid, st_data, kw_valid, kw_data,
    input  st_ready, st_out_valid, st_out, kw_ready, kw_out_valid, kw_out, busy
  );

  modport slave (
    input  st_valid, st_data, kw_valid, kw_data,
    output st_ready, st_out_valid, st_out, kw_ready, kw_out_valid, kw_out, busy
  );
endinterface

// File: rtl/sbox_arbiter.sv
// Four shared AES forward S-boxes time-multiplexed between a 128-bit SubBytes
// requester (four passes) and a 32-bit SubWord key-schedule requester (one pass).
module sbox_arbiter #(
  parameter bit KEY_PRIO = 1'b0
) (
  input logic          clk,
  input logic          rst,
  sbox_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ST0, ST1, ST2, ST3, KW} state_t;

  state_t       state;
  logic [127:0] st_cap;
  logic [31:0]  kw_cap;
  logic [95:0]  st_acc;
  logic [127:0] st_out_q;
  logic [31:0]  kw_out_q;
  logic         st_pulse;
  logic         kw_pulse;
  logic         last_key;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_res;
  logic         idle;
  logic         key_wins;
  logic         kw_grant;
  logic         st_grant;

  // Readiness is withheld while rst is high so a handshake is never offered that cannot complete.
  assign idle     = (state == IDLE) && !rst;
  assign key_wins = KEY_PRIO || !last_key;
  assign kw_grant = idle && bus.kw_valid && (!bus.st_valid || key_wins);
  assign st_grant = idle && bus.st_valid && !kw_grant;

  always_comb begin
    sbox_in = 32'h0;
    case (state)
      ST0:     sbox_in = st_cap[127:96];
      ST1:     sbox_in = st_cap[95:64];
      ST2:     sbox_in = st_cap[63:32];
      ST3:     sbox_in = st_cap[31:0];
      KW:      sbox_in = kw_cap;
      default: sbox_in = 32'h0;
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sbox_in[8*g +: 8]),
      .y (sbox_res[8*g +: 8])
    );
  end

  // Words 0..2 accumulate privately so st_out changes all at once with the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      st_cap   <= '0;
      kw_cap   <= '0;
      st_acc   <= '0;
      st_out_q <= '0;
      kw_out_q <= '0;
      st_pulse <= 1'b0;
      kw_pulse <= 1'b0;
      last_key <= 1'b0;
    end else begin
      st_pulse <= 1'b0;
      kw_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (kw_grant) begin
            kw_cap   <= bus.kw_data;
            last_key <= 1'b1;
            state    <= KW;
          end else if (st_grant) begin
            st_cap   <= bus.st_data;
            last_key <= 1'b0;
            state    <= ST0;
          end
        end
        ST0: begin
          st_acc[95:64] <= sbox_res;
          state         <= ST1;
        end
        ST1: begin
          st_acc[63:32] <= sbox_res;
          state         <= ST2;
        end
        ST2: begin
          st_acc[31:0] <= sbox_res;
          state        <= ST3;
        end
        ST3: begin
          st_out_q <= {st_acc, sbox_res};
          st_pulse <= 1'b1;
          state    <= IDLE;
        end
        KW: begin
          kw_out_q <= sbox_res;
          kw_pulse <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.st_ready     = st_grant;
  assign bus.kw_ready     = kw_grant;
  assign bus.st_out_valid = st_pulse;
  assign bus.st_out       = st_out_q;
  assign bus.kw_out_valid = kw_pulse;
  assign bus.kw_out       = kw_out_q;
  assign bus.busy         = (state != IDLE);

endmodule

// AES forward S-box as a 256-entry lookup; entry 0 is the leftmost byte.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = TABLE[a];

endmodule
